// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command decoder: opcodes, FSM state
// encoding and reply-word tags.
package spi_cmd_pkg;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_WRITE      = 4'h1;
  localparam logic [3:0] OP_READ       = 4'h2;
  localparam logic [3:0] OP_WIDE_WRITE = 4'h3;
  localparam logic [3:0] OP_CLR_ERR    = 4'h4;

  localparam logic [3:0] TAG_ERR     = 4'hF;
  localparam logic [7:0] ARG_TIMEOUT = 8'hEE;
  localparam logic [7:0] ARG_BAD_OP  = 8'hFF;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_EXT = 1'b1
  } state_t;

  function automatic logic [15:0] bad_op_reply(input logic [3:0] opcode);
    return {TAG_ERR, opcode, ARG_BAD_OP};
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_if.sv
// Word-level link between the SPI slave shifter and the command decoder.
interface spi_cmd_decoder_if;
  logic        word_valid;
  logic [15:0] word_data;
  logic [15:0] tx_word;

  modport master (output word_valid, output word_data, input tx_word);
  modport slave  (input word_valid, input word_data, output tx_word);
endinterface

// File: rtl/spi_cmd_decoder.sv
// Decodes 16-bit SPI command words into register writes/reads and a two-word
// wide write with an idle timeout; every result is registered one cycle later.
//
// state       | meaning
// ST_IDLE     | decoding command words
// ST_WAIT_EXT | next word is the raw wide-write payload; timeout running
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4_800_000,
  parameter int NUM_REGS       = 8
) (
  input  logic        clk,
  input  logic        rst,
  spi_cmd_decoder_if.slave spi,
  output logic [7:0]  reg_ctrl,
  output logic [7:0]  reg_led,
  output logic [15:0] wide_value,
  output logic        wide_update,
  output logic [7:0]  err_count,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_next;
  logic [7:0]        regs [NUM_REGS];
  logic [15:0]       tx_q, tx_next;
  logic [7:0]        err_next;
  logic              reg_we, wide_load, err_inc, err_clr;

  logic [3:0]        opcode, addr;
  logic [7:0]        data;
  logic [IDX_W-1:0]  idx;
  logic              addr_ok, timeout_hit;

  assign opcode  = spi.word_data[15:12];
  assign addr    = spi.word_data[11:8];
  assign data    = spi.word_data[7:0];
  assign idx     = addr[IDX_W-1:0];
  assign addr_ok = int'(addr) < NUM_REGS;

  // A payload word in the terminal cycle wins over the timeout.
  assign timeout_hit = (state == ST_WAIT_EXT) && !spi.word_valid && (tmo_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:
        if (spi.word_valid && opcode == OP_WIDE_WRITE) state_next = ST_WAIT_EXT;
      ST_WAIT_EXT:
        if (spi.word_valid || timeout_hit) state_next = ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_next      = tx_q;
    tmo_cnt_next = tmo_cnt;
    reg_we       = 1'b0;
    wide_load    = 1'b0;
    err_inc      = 1'b0;
    err_clr      = 1'b0;
    case (state)
      ST_IDLE: begin
        tmo_cnt_next = '0;
        if (spi.word_valid) begin
          case (opcode)
            OP_NOP: ;
            OP_WRITE:
              if (addr_ok) begin
                reg_we  = 1'b1;
                tx_next = {OP_WRITE, addr, data};
              end else begin
                err_inc = 1'b1;
                tx_next = bad_op_reply(opcode);
              end
            OP_READ:
              if (addr_ok) begin
                tx_next = {OP_READ, addr, regs[idx]};
              end else begin
                err_inc = 1'b1;
                tx_next = bad_op_reply(opcode);
              end
            OP_WIDE_WRITE: tx_next = {OP_WIDE_WRITE, 12'h000};
            OP_CLR_ERR: begin
              err_clr = 1'b1;
              tx_next = {OP_CLR_ERR, 12'h000};
            end
            default: begin
              err_inc = 1'b1;
              tx_next = bad_op_reply(opcode);
            end
          endcase
        end
      end
      ST_WAIT_EXT: begin
        if (spi.word_valid) begin
          wide_load    = 1'b1;
          tx_next      = {OP_WIDE_WRITE, 12'h001};
          tmo_cnt_next = '0;
        end else if (timeout_hit) begin
          err_inc      = 1'b1;
          tx_next      = {TAG_ERR, OP_WIDE_WRITE, ARG_TIMEOUT};
          tmo_cnt_next = '0;
        end else begin
          tmo_cnt_next = tmo_cnt + 1'b1;
        end
      end
      default: ;
    endcase

    if (err_clr)                          err_next = 8'h00;
    else if (err_inc && err_count != 8'hFF) err_next = err_count + 8'h01;
    else                                  err_next = err_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q        <= 16'h0000;
      tmo_cnt     <= '0;
      err_count   <= 8'h00;
      wide_value  <= 16'h0000;
      wide_update <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      tx_q        <= tx_next;
      tmo_cnt     <= tmo_cnt_next;
      err_count   <= err_next;
      wide_update <= wide_load;
      if (wide_load) wide_value <= spi.word_data;
      if (reg_we)    regs[idx]  <= data;
    end
  end

  assign spi.tx_word = tx_q;
  assign reg_ctrl    = regs[0];
  assign reg_led     = regs[1];
  assign busy        = (state == ST_WAIT_EXT);

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: a reference model queues the expected
// outputs of every cycle, and they are compared after the following edge.
module tb_spi_cmd_decoder;

  localparam int TMO = 100;

  typedef struct {
    logic [15:0] tx;
    logic [7:0]  err;
    logic [15:0] wide;
    logic        upd;
    logic        busy;
    logic [7:0]  ctrl;
    logic [7:0]  led;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0]  reg_ctrl, reg_led, err_count;
  logic [15:0] wide_value;
  logic        wide_update, busy;

  spi_cmd_decoder_if link ();

  spi_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .NUM_REGS(8)) dut (
    .clk(clk), .rst(rst), .spi(link),
    .reg_ctrl(reg_ctrl), .reg_led(reg_led), .wide_value(wide_value),
    .wide_update(wide_update), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  exp_t sb[$];

  logic        m_busy;
  int          m_idle;
  logic [7:0]  m_regs [8];
  logic [7:0]  m_err;
  logic [15:0] m_tx, m_wide;
  logic        m_upd;

  task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  task automatic m_bad();
    if (m_err != 8'hFF) m_err = m_err + 8'h01;
  endtask

  task automatic model_step(input logic r, input logic v, input logic [15:0] d);
    logic [3:0] op, a;
    exp_t e;
    op = d[15:12];
    a  = d[11:8];
    m_upd = 1'b0;
    if (r) begin
      m_busy = 1'b0; m_idle = 0; m_err = 8'h00; m_tx = 16'h0000; m_wide = 16'h0000;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    end else if (m_busy) begin
      if (v) begin
        m_wide = d; m_upd = 1'b1; m_tx = 16'h3001; m_busy = 1'b0;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_busy = 1'b0; m_bad(); m_tx = 16'hF3EE;
        end
      end
    end else if (v) begin
      case (op)
        4'h0: ;
        4'h1: if (a < 8) begin m_regs[a[2:0]] = d[7:0]; m_tx = d; end
              else begin m_bad(); m_tx = {4'hF, op, 8'hFF}; end
        4'h2: if (a < 8) m_tx = {4'h2, a, m_regs[a[2:0]]};
              else begin m_bad(); m_tx = {4'hF, op, 8'hFF}; end
        4'h3: begin m_busy = 1'b1; m_idle = 0; m_tx = 16'h3000; end
        4'h4: begin m_err = 8'h00; m_tx = 16'h4000; end
        default: begin m_bad(); m_tx = {4'hF, op, 8'hFF}; end
      endcase
    end
    e.tx = m_tx; e.err = m_err; e.wide = m_wide; e.upd = m_upd;
    e.busy = m_busy; e.ctrl = m_regs[0]; e.led = m_regs[1];
    sb.push_back(e);
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    rst = r;
    link.word_valid = v;
    link.word_data  = d;
    model_step(r, v, d);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check("sb_tx", link.tx_word, e.tx);
      check("sb_err", {8'h00, err_count}, {8'h00, e.err});
      check("sb_wide", wide_value, e.wide);
      check("sb_upd", {15'h0, wide_update}, {15'h0, e.upd});
      check("sb_busy", {15'h0, busy}, {15'h0, e.busy});
      check("sb_ctrl", {8'h00, reg_ctrl}, {8'h00, e.ctrl});
      check("sb_led", {8'h00, reg_led}, {8'h00, e.led});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    link.word_valid = 1'b0;
    link.word_data  = 16'h0000;

    // reset state
    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'h1155);
    check("rst_tx", link.tx_word, 16'h0000);
    check("rst_busy", {15'h0, busy}, 16'h0000);
    check("rst_led", {8'h00, reg_led}, 16'h0000);

    // write then read back
    step(1'b0, 1'b1, 16'h1155);
    check("write_tx", link.tx_word, 16'h1155);
    step(1'b0, 1'b1, 16'h2100);
    check("read_tx", link.tx_word, 16'h2155);
    check("read_led", {8'h00, reg_led}, 16'h0055);
    step(1'b0, 1'b1, 16'h1077);
    check("ctrl_mirror", {8'h00, reg_ctrl}, 16'h0077);
    step(1'b0, 1'b1, 16'h0000);
    check("nop_tx", link.tx_word, 16'h1077);

    // wide write
    step(1'b0, 1'b1, 16'h3000);
    check("wide_hdr_tx", link.tx_word, 16'h3000);
    idle(3);
    check("wide_busy", {15'h0, busy}, 16'h0001);
    step(1'b0, 1'b1, 16'hBEEF);
    check("wide_value", wide_value, 16'hBEEF);
    check("wide_upd", {15'h0, wide_update}, 16'h0001);
    check("wide_tx", link.tx_word, 16'h3001);
    idle(1);
    check("wide_upd_once", {15'h0, wide_update}, 16'h0000);

    // protocol errors and saturation
    step(1'b0, 1'b1, 16'h1A00);
    check("bad_addr_tx", link.tx_word, 16'hF1FF);
    step(1'b0, 1'b1, 16'h7000);
    check("bad_op_err", {8'h00, err_count}, 16'h0002);
    check("bad_op_tx", link.tx_word, 16'hF7FF);
    step(1'b0, 1'b1, 16'h2800);
    check("bad_read_tx", link.tx_word, 16'hF2FF);
    step(1'b0, 1'b1, 16'h4000);
    check("clr_err", {8'h00, err_count}, 16'h0000);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 16'h5123);
    check("err_sat", {8'h00, err_count}, 16'h00FF);
    step(1'b0, 1'b1, 16'h4000);
    check("clr_after_sat", {8'h00, err_count}, 16'h0000);

    // back-to-back words, including wide payload
    step(1'b0, 1'b1, 16'h1233);
    step(1'b0, 1'b1, 16'h2200);
    check("b2b_read", link.tx_word, 16'h2233);
    step(1'b0, 1'b1, 16'h3000);
    step(1'b0, 1'b1, 16'h1111);
    check("b2b_wide", wide_value, 16'h1111);
    step(1'b0, 1'b1, 16'h2100);
    check("b2b_after", link.tx_word, 16'h2155);

    // timeout
    step(1'b0, 1'b1, 16'h3000);
    idle(TMO - 1);
    check("tmo_not_yet", {15'h0, busy}, 16'h0001);
    idle(1);
    check("tmo_busy", {15'h0, busy}, 16'h0000);
    check("tmo_err", {8'h00, err_count}, 16'h0001);
    check("tmo_tx", link.tx_word, 16'hF3EE);
    check("tmo_wide_kept", wide_value, 16'h1111);

    // payload on the terminal cycle is accepted
    step(1'b0, 1'b1, 16'h4000);
    step(1'b0, 1'b1, 16'h3000);
    idle(TMO - 1);
    step(1'b0, 1'b1, 16'h1234);
    check("edge_wide", wide_value, 16'h1234);
    check("edge_err", {8'h00, err_count}, 16'h0000);
    check("edge_tx", link.tx_word, 16'h3001);
    idle(2);
    check("edge_err_later", {8'h00, err_count}, 16'h0000);

    // reset in WAIT_EXT with a coincident word
    step(1'b0, 1'b1, 16'h7000);
    step(1'b0, 1'b1, 16'h3000);
    step(1'b1, 1'b1, 16'h5678);
    check("mid_rst_busy", {15'h0, busy}, 16'h0000);
    check("mid_rst_wide", wide_value, 16'h0000);
    check("mid_rst_err", {8'h00, err_count}, 16'h0000);
    check("mid_rst_tx", link.tx_word, 16'h0000);
    step(1'b0, 1'b1, 16'h3000);
    step(1'b0, 1'b1, 16'hABCD);
    check("post_rst_wide", wide_value, 16'hABCD);
    check("post_rst_tx", link.tx_word, 16'h3001);
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
